ternary_serial_alu: RTL

TERNARY_SERIAL_ALU -- requirements
Module: ternary_serial_alu

---
 rtl/ternary_serial_alu.sv | 116 +++++++++++
 1 files changed

// File: rtl/ternary_serial_alu.sv
// Bit-serial balanced-free ternary ALU: captures two WIDTH-trit words, computes one trit per cycle, holds result until taken.
// Optional illegal-code (11) checking is enabled by defining TERNARY_ILLEGAL_CHECK_EN.
module ternary_serial_alu #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {OP_MIN = 2'b00, OP_MAX = 2'b01, OP_ANY = 2'b10, OP_CONS = 2'b11} op_e;

  state_e              state, state_d;
  op_e                 op_q;
  logic [2*WIDTH-1:0]  a_q, b_q, result_q, result_d;
  logic [4:0]          cnt_q;
  logic                capture, step, last;
  logic [1:0]          ta, tb, trit_raw, trit;

  // Codes are treated as plain 2-bit numbers, so an illegal 11 flows through as the value 3.
  function automatic logic [1:0] trit_op(input op_e o, input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    case (o)
      OP_MIN:  trit_op = (x < y) ? x : y;
      OP_MAX:  trit_op = (x > y) ? x : y;
      OP_ANY:  trit_op = (s == 3'd0) ? 2'd0 : (s >= 3'd3) ? 2'd2 : s[1:0] - 2'd1;
      default: trit_op = (x == y) ? x : 2'd1;
    endcase
  endfunction

  assign capture = (state == IDLE) && in_valid;
  assign step    = (state == RUN);
  assign last    = (cnt_q == 5'(WIDTH - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands shift right as they are consumed, so the current trit is always at [1:0].
  assign ta       = a_q[1:0];
  assign tb       = b_q[1:0];
  assign trit_raw = trit_op(op_q, ta, tb);

`ifdef TERNARY_ILLEGAL_CHECK_EN
  logic illegal, err_q;
  assign illegal = (ta == 2'b11) || (tb == 2'b11);
  assign trit    = illegal ? 2'b00 : trit_raw;
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_q <= 1'b0;
    else if (capture)           err_q <= 1'b0;
    else if (step && illegal)   err_q <= 1'b1;
  end
`else
  assign trit = trit_raw;
  assign err  = 1'b0;
`endif

  always_comb begin
    result_d = result_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_q == 5'(i)) result_d[2*i +: 2] = trit;
    end
  end

  // NOTE: the captured operands are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_MIN;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (capture) begin
      a_q      <= a;
      b_q      <= b;
      op_q     <= op_e'(op);
      cnt_q    <= '0;
      result_q <= '0;
    end else if (step) begin
      a_q      <= a_q >> 2;
      b_q      <= b_q >> 2;
      cnt_q    <= cnt_q + 5'd1;
      result_q <= result_d;
    end
  end

endmodule
